// File: rtl/ceu_route_ctrl_pkg.sv
// Shared route types for the CEU data switch route scheduler.
// Holds the route word width, the reset route pattern and the per-region FSM encoding.
package ceu_route_ctrl_pkg;

   localparam int ROUTE_BITS = 14;

   typedef logic [ROUTE_BITS-1:0] route_t;

   localparam route_t RST_ROUTE_BASE = 14'b01001111111100;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } slot_state_t;

   // Region index lands in bits [11:10] of the reset route.
   function automatic route_t reset_route(input int idx);
      route_t r;
      r        = RST_ROUTE_BASE;
      r[11:10] = idx[1:0];
      return r;
   endfunction

endpackage

// File: rtl/ceu_route_slot.sv
// One region's route slot: packet-boundary tracker, single pending update,
// wait timer and sticky timeout flag.
module ceu_route_slot
   import ceu_route_ctrl_pkg::*;
#(
   parameter int IDX            = 0,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  wr,
   input  logic [ROUTE_BITS-1:0] wr_route,
   input  logic                  tvalid,
   input  logic                  tready,
   input  logic                  tlast,
   input  logic                  err_clr,
   output logic [ROUTE_BITS-1:0] route,
   output logic                  pkt_active,
   output logic                  upd_pending,
   output logic                  to_err
);

   localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  T_MAX     = TW'(TIMEOUT_CYCLES);
   localparam route_t         RST_ROUTE = reset_route(IDX);

   slot_state_t   state;
   logic          hs;
   logic          idle_next;
   logic          apply;
   logic          to_set;
   logic [TW-1:0] timer;
   route_t        pend_route;

   assign hs         = tvalid & tready;
   assign idle_next  = ((state == S_IDLE) && !(hs && !tlast)) ||
                       ((state == S_ACTIVE) && hs && tlast);
   assign apply      = upd_pending & idle_next;
   // Timeout fires once, on the step into saturation, so err_clr can clear it while still stalled.
   assign to_set     = upd_pending & ~apply & (timer == T_MAX - 1'b1);
   assign pkt_active = (state == S_ACTIVE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= S_IDLE;
         upd_pending <= 1'b0;
         timer       <= '0;
         to_err      <= 1'b0;
         route       <= RST_ROUTE;
      end else begin
         case (state)
            S_IDLE:   if (hs && !tlast) state <= S_ACTIVE;
            S_ACTIVE: if (hs && tlast)  state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase

         if (apply) begin
            route       <= pend_route;
            upd_pending <= 1'b0;
            timer       <= '0;
         end else if (wr) begin
            upd_pending <= 1'b1;
            timer       <= '0;
         end else if (upd_pending && (timer != T_MAX)) begin
            timer <= timer + 1'b1;
         end

         if (to_set)       to_err <= 1'b1;
         else if (err_clr) to_err <= 1'b0;
      end
   end

   // Only read while upd_pending is set, so it needs no reset.
   always_ff @(posedge aclk) begin
      if (wr) pend_route <= wr_route;
   end

endmodule

// File: rtl/ceu_route_ctrl.sv
// Route scheduler top: decodes control-plane route updates and hands them
// to per-region slots that apply them only at packet boundaries.
module ceu_route_ctrl
   import ceu_route_ctrl_pkg::*;
#(
   parameter int N_ID           = 4,
   parameter int ID_BITS        = (N_ID > 1) ? $clog2(N_ID) : 1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [ID_BITS-1:0]           cfg_id,
   input  logic [ROUTE_BITS-1:0]        cfg_route,
   output logic                         cfg_err,
   input  logic [N_ID-1:0]              mon_tvalid,
   input  logic [N_ID-1:0]              mon_tready,
   input  logic [N_ID-1:0]              mon_tlast,
   output logic [N_ID*ROUTE_BITS-1:0]   route_out,
   output logic [N_ID-1:0]              pkt_active,
   output logic [N_ID-1:0]              upd_pending,
   output logic [N_ID-1:0]              to_err,
   input  logic [N_ID-1:0]              err_clr
);

   logic [N_ID-1:0] wr;
   logic            id_ok;

   // Out-of-range ids are always accepted so the control plane never stalls on them.
   always_comb begin
      wr        = '0;
      id_ok     = 1'b0;
      cfg_ready = 1'b1;
      for (int i = 0; i < N_ID; i++) begin
         if (cfg_id == ID_BITS'(i)) begin
            id_ok = 1'b1;
            if (upd_pending[i]) cfg_ready = 1'b0;
         end
      end
      for (int i = 0; i < N_ID; i++) begin
         wr[i] = cfg_valid & cfg_ready & (cfg_id == ID_BITS'(i));
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) cfg_err <= 1'b0;
      else          cfg_err <= cfg_valid & ~id_ok;
   end

   for (genvar i = 0; i < N_ID; i++) begin : g_slot
      ceu_route_slot #(
         .IDX            (i),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_slot (
         .aclk        (aclk),
         .aresetn     (aresetn),
         .wr          (wr[i]),
         .wr_route    (cfg_route),
         .tvalid      (mon_tvalid[i]),
         .tready      (mon_tready[i]),
         .tlast       (mon_tlast[i]),
         .err_clr     (err_clr[i]),
         .route       (route_out[i*ROUTE_BITS +: ROUTE_BITS]),
         .pkt_active  (pkt_active[i]),
         .upd_pending (upd_pending[i]),
         .to_err      (to_err[i])
      );
   end

endmodule

// File: tb/tb_ceu_route_ctrl.sv
// Randomized + directed bench for ceu_route_ctrl against a packet-level reference model.
module tb_ceu_route_ctrl;

   localparam int N  = 4;
   localparam int IB = 3;
   localparam int RB = 14;
   localparam int T  = 40;

   logic            aclk;
   logic            aresetn;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [IB-1:0]   cfg_id;
   logic [RB-1:0]   cfg_route;
   logic            cfg_err;
   logic [N-1:0]    mon_tvalid;
   logic [N-1:0]    mon_tready;
   logic [N-1:0]    mon_tlast;
   logic [N*RB-1:0] route_out;
   logic [N-1:0]    pkt_active;
   logic [N-1:0]    upd_pending;
   logic [N-1:0]    to_err;
   logic [N-1:0]    err_clr;

   ceu_route_ctrl #(.N_ID(N), .ID_BITS(IB), .TIMEOUT_CYCLES(T)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_id      (cfg_id),
      .cfg_route   (cfg_route),
      .cfg_err     (cfg_err),
      .mon_tvalid  (mon_tvalid),
      .mon_tready  (mon_tready),
      .mon_tlast   (mon_tlast),
      .route_out   (route_out),
      .pkt_active  (pkt_active),
      .upd_pending (upd_pending),
      .to_err      (to_err),
      .err_clr     (err_clr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // Reference model: packet-in-flight flag, queued update and wait count per region.
   bit          m_pkt  [N];
   bit          m_pend [N];
   logic [13:0] m_prt  [N];
   int          m_wait [N];
   bit          m_err  [N];
   logic [13:0] m_rt   [N];
   bit          m_cerr;
   bit          m_acc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [13:0] rst_rt(input int i);
      return 14'h13FC | 14'(i << 10);
   endfunction

   function automatic logic [13:0] rt_of(input int i);
      return route_out[i*RB +: RB];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pkt[i]  = 0;
         m_pend[i] = 0;
         m_prt[i]  = '0;
         m_wait[i] = 0;
         m_err[i]  = 0;
         m_rt[i]   = rst_rt(i);
      end
      m_cerr = 0;
      m_acc  = 0;
   endtask

   function automatic bit m_ready();
      int id = int'(cfg_id);
      if (id < N && m_pend[id]) return 0;
      return 1;
   endfunction

   task automatic model_step();
      int id   = int'(cfg_id);
      bit rdy  = m_ready();
      m_acc  = cfg_valid && rdy;
      m_cerr = cfg_valid && (id >= N);
      for (int i = 0; i < N; i++) begin
         bit hs       = mon_tvalid[i] && mon_tready[i];
         bit in_next  = hs ? !mon_tlast[i] : m_pkt[i];
         bit set_e    = 0;
         if (m_pend[i] && !in_next) begin
            m_rt[i]   = m_prt[i];
            m_pend[i] = 0;
            m_wait[i] = 0;
         end else if (m_pend[i]) begin
            m_wait[i]++;
            if (m_wait[i] == T) set_e = 1;
         end
         if (set_e)           m_err[i] = 1;
         else if (err_clr[i]) m_err[i] = 0;
         if (m_acc && id == i) begin
            m_pend[i] = 1;
            m_prt[i]  = cfg_route;
            m_wait[i] = 0;
         end
         m_pkt[i] = in_next;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("route%0d", i), rt_of(i), m_rt[i]);
         chk($sformatf("pkt_active%0d", i), pkt_active[i], m_pkt[i]);
         chk($sformatf("upd_pending%0d", i), upd_pending[i], m_pend[i]);
         chk($sformatf("to_err%0d", i), to_err[i], m_err[i]);
      end
      chk("cfg_err", cfg_err, m_cerr);
   endtask

   task automatic tick();
      @(negedge aclk);
      chk("cfg_ready", cfg_ready, m_ready());
      model_step();
      @(posedge aclk);
      #1;
      compare_all();
   endtask

   task automatic quiet();
      cfg_valid  = 0;
      mon_tvalid = '0;
      mon_tready = '0;
      mon_tlast  = '0;
      err_clr    = '0;
   endtask

   task automatic beat(input int r, input bit rdy, input bit last);
      mon_tvalid[r] = 1;
      mon_tready[r] = rdy;
      mon_tlast[r]  = last;
   endtask

   task automatic cfg_write(input int id, input logic [13:0] rt);
      bit done = 0;
      cfg_valid = 1;
      cfg_id    = IB'(id);
      cfg_route = rt;
      for (int n = 0; n < 100 && !done; n++) begin
         tick();
         done = m_acc;
      end
      if (!done) chk("cfg_accept_timeout", 0, 1);
      cfg_valid = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn   = 0;
      cfg_id    = '0;
      cfg_route = '0;
      quiet();
      model_reset();
      #23;
      chk("rst_async_route0", rt_of(0), 14'h13FC);
      @(negedge aclk);
      aresetn = 1;
      @(posedge aclk);
      #1;

      // 1: reset state
      chk("rst_route0", rt_of(0), 14'h13FC);
      chk("rst_route1", rt_of(1), 14'h17FC);
      chk("rst_route2", rt_of(2), 14'h1BFC);
      chk("rst_route3", rt_of(3), 14'h1FFC);
      chk("rst_status", {pkt_active, upd_pending, to_err}, '0);
      chk("rst_cfg_ready", cfg_ready, 1);
      compare_all();

      // 2: idle region, one-edge apply
      cfg_write(1, 14'h0010);
      chk("t2_pending", upd_pending[1], 1);
      chk("t2_route_old", rt_of(1), 14'h17FC);
      tick();
      chk("t2_route_new", rt_of(1), 14'h0010);
      chk("t2_pending_clr", upd_pending[1], 0);
      chk("t2_route0", rt_of(0), 14'h13FC);

      // 3: update waits for tlast of an in-flight packet
      beat(0, 1, 0);
      tick();
      quiet();
      cfg_write(0, 14'h0020);
      begin
         int beats = 0;
         for (int c = 0; c < 40 && beats < 5; c++) begin
            bit h;
            beat(0, c[0], beats == 4);
            h = c[0];
            tick();
            if (h) beats++;
            if (beats < 5) chk("t3_route_hold", rt_of(0), 14'h13FC);
         end
         if (beats < 5) chk("t3_beats_timeout", beats, 5);
      end
      quiet();
      chk("t3_route_new", rt_of(0), 14'h0020);
      chk("t3_pkt_idle", pkt_active[0], 0);

      // 4: back-to-back updates to one region
      beat(2, 1, 0);
      tick();
      quiet();
      cfg_write(2, 14'h0123);
      cfg_valid = 1;
      cfg_id    = IB'(2);
      cfg_route = 14'h0234;
      repeat (3) begin
         tick();
         chk("t4_ready_low", cfg_ready, 0);
      end
      beat(2, 1, 1);
      tick();
      chk("t4_route_first", rt_of(2), 14'h0123);
      chk("t4_ready_back", cfg_ready, 1);
      quiet();
      cfg_valid = 1;
      tick();
      chk("t4_second_pending", upd_pending[2], 1);
      cfg_valid = 0;
      tick();
      chk("t4_route_second", rt_of(2), 14'h0234);
      repeat (3) begin
         beat(2, 1, 1);
         tick();
         chk("t4_single_beat", pkt_active[2], 0);
      end
      quiet();

      // 5: stalled packet raises timeout, route held
      beat(3, 1, 0);
      tick();
      quiet();
      cfg_write(3, 14'h0345);
      beat(3, 0, 1);
      repeat (T + 3) tick();
      chk("t5_to_err_set", to_err[3], 1);
      chk("t5_route_held", rt_of(3), 14'h1FFC);
      err_clr[3] = 1;
      tick();
      err_clr[3] = 0;
      chk("t5_to_err_clr", to_err[3], 0);
      repeat (5) tick();
      chk("t5_to_err_stays_clr", to_err[3], 0);
      beat(3, 1, 1);
      tick();
      quiet();
      chk("t5_route_applied", rt_of(3), 14'h0345);

      // 6: invalid id and async reset mid-packet
      cfg_valid = 1;
      cfg_id    = IB'(5);
      cfg_route = 14'h3FFF;
      tick();
      cfg_valid = 0;
      chk("t6_cfg_err", cfg_err, 1);
      tick();
      chk("t6_cfg_err_pulse", cfg_err, 0);
      beat(0, 1, 0);
      beat(1, 1, 0);
      tick();
      quiet();
      cfg_write(0, 14'h0AAA);
      cfg_write(1, 14'h0BBB);
      chk("t6_pre_pending", upd_pending[1:0], 2'b11);
      #2;
      aresetn = 0;
      #1;
      model_reset();
      chk("t6_rst_route0", rt_of(0), 14'h13FC);
      chk("t6_rst_route1", rt_of(1), 14'h17FC);
      chk("t6_rst_route2", rt_of(2), 14'h1BFC);
      chk("t6_rst_status", {pkt_active, upd_pending, to_err}, '0);
      compare_all();
      @(negedge aclk);
      aresetn = 1;
      @(posedge aclk);
      #1;
      compare_all();

      // Randomized traffic against the model
      begin
         bit [N-1:0] stall;
         stall = '0;
         for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) stall = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
               mon_tvalid[i] = ($urandom_range(0, 9) < 7);
               mon_tready[i] = stall[i] ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 6);
               mon_tlast[i]  = ($urandom_range(0, 3) == 0);
               err_clr[i]    = ($urandom_range(0, 19) == 0);
            end
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_id    = IB'($urandom_range(0, 5));
            cfg_route = 14'($urandom);
            tick();
         end
      end
      quiet();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ceu_route_ctrl.md
Name: ceu_route_ctrl

Overview:
Per-region route scheduler for the CEU data switch. It holds the 14-bit route word for each vFPGA region's DTU sink stream and accepts route-change requests from the control plane. A new route is applied only at packet boundaries, so tdest never changes while a packet is in flight. Sits between the control/CSR logic and the switch's route_in vector, and snoops each DTU sink handshake.

Parameters:
N_ID, N_REGIONS, number of vFPGA regions (one route slot per region)
ROUTE_BITS, 14, route/tdest word width
RST_ROUTE_BASE, 14'b01001111111100, reset route; region i resets to RST_ROUTE_BASE with bits[11:10] = i
TIMEOUT_CYCLES, 4096, cycles a pending update may wait before the timeout flag is raised

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous assert, active-low
cfg_valid  in  1  route update request valid
cfg_ready  out  1  route update request accepted when high with cfg_valid
cfg_id  in  $clog2(N_ID)  target region index
cfg_route  in  ROUTE_BITS  new route word
cfg_err  out  1  one-cycle pulse: accepted request had cfg_id >= N_ID, request dropped
mon_tvalid  in  N_ID  DTU sink tvalid per region (snoop)
mon_tready  in  N_ID  DTU sink tready per region (snoop)
mon_tlast  in  N_ID  DTU sink tlast per region (snoop)
route_out  out  N_ID x ROUTE_BITS  registered route per region, drives switch route_in
pkt_active  out  N_ID  region is mid-packet
upd_pending  out  N_ID  region has a queued update
to_err  out  N_ID  sticky timeout flag per region
err_clr  in  N_ID  clears to_err per region

Behaviour:
- Reset values: route_out[i] = RST_ROUTE_BASE | (i<<10); pkt_active = 0; upd_pending = 0; to_err = 0; cfg_err = 0; all timers = 0.
- Handshake for region i: hs = mon_tvalid & mon_tready.
- Per-region FSM, IDLE / ACTIVE:
  - IDLE -> ACTIVE on hs & !tlast.
  - IDLE stays IDLE on hs & tlast (single-beat packet).
  - ACTIVE -> IDLE on hs & tlast.
  - pkt_active = (state == ACTIVE).
- Boundary signal: idle_next = (IDLE & !(hs & !tlast)) | (ACTIVE & hs & tlast).
- Pending slot: one per region, holding pend_route.
  - cfg_ready = !(cfg_id < N_ID && upd_pending[cfg_id]). It is combinational from cfg_id and the registered pending flags.
  - An accept (cfg_valid & cfg_ready) with a valid cfg_id sets upd_pending and pend_route at edge E.
- Apply rule: at an edge where upd_pending (registered) & idle_next, route_out <= pend_route and upd_pending <= 0.
  - Minimum latency: accept at edge E0, route_out changes at E0+1 if the region stays idle.
  - A first beat in the same cycle as the accept uses the old route; the update then waits for that packet's tlast.
  - Clearing the pending flag and accepting a new request for the same region cannot happen in the same cycle, because cfg_ready is low while the flag is set. The new request is accepted the cycle after the apply.
- Timer: counts while upd_pending and saturates at TIMEOUT_CYCLES. When the count reaches TIMEOUT_CYCLES, to_err sets (sticky).
  - The update stays pending; it is never dropped or forced mid-packet.
  - The timer clears on apply.
  - err_clr clears to_err. If err_clr and the set condition occur in the same cycle, set wins.
- Invalid cfg_id: the request is accepted (cfg_ready = 1) and dropped, and cfg_err pulses high for 1 cycle, registered.
- tvalid held without tready has no effect on state or route.
- Reset asserted mid-packet: all regions return to IDLE with reset routes, and pending updates are discarded.

Decomposition:
- Shared package (lynxTypes): ROUTE_BITS = 14, typedef route_t = logic [ROUTE_BITS-1:0], RST_ROUTE_BASE.
- One sub-module, ceu_route_slot, instantiated N_ID times. It contains the FSM, the pending slot, the timer and the to_err flag.
- The top level does cfg_id decode, cfg_ready/cfg_err generation and slot instantiation.

Test Plan:
1. Reset -> route_out[0..3] = 14'h13FC, 14'h17FC, 14'h1BFC, 14'h1FFC; all status outputs 0; cfg_ready = 1.
2. Region 1 idle; write cfg_id=1, route=14'h0010 -> upd_pending[1] high for 1 cycle; route_out[1] = 14'h0010 one edge after accept; other regions unchanged.
3. Region 0: first beat (tlast=0) accepted, then write route 14'h0020 to region 0; 5 beats with tready toggling, tlast on 5th -> route_out[0] holds old value through every beat and changes at the edge of the tlast handshake.
4. Region 2 pending; second write to cfg_id=2 -> cfg_ready = 0 until the apply cycle, accepted on the next cycle, second route applied afterwards; single-beat packets (tlast=1 on first beat) do not set pkt_active.
5. Region 3 packet stalled (tvalid=1, tready=0) with an update pending for TIMEOUT_CYCLES -> to_err[3] = 1 and route unchanged; err_clr[3] -> to_err[3] = 0; then tlast handshake -> route applied.
6. cfg_id = 5 with N_ID = 4 -> accepted, cfg_err pulses 1 cycle, no route changes. Separately, assert aresetn low mid-packet with updates pending -> outputs return to reset values asynchronously.
